// File: rtl/axis_burst_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream slave among num_req masters.
// Each grant covers one fixed burst of trans_lenth beats, preceded by a one-cycle en pulse.
module axis_burst_arbiter #(
    parameter int data_width  = 32,
    parameter int trans_width = 4,
    parameter int trans_lenth = 2**trans_width,
    parameter int num_req     = 4,
    parameter int req_width   = $clog2(num_req)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [num_req*data_width-1:0] s_data,
    input  logic [num_req-1:0]            s_valid,
    output logic [num_req-1:0]            s_ready,
    output logic [data_width-1:0]         m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          en,
    output logic [num_req-1:0]            grant,
    output logic                          busy,
    output logic                          burst_done
);

    typedef enum logic [1:0] {IDLE, EN, XFER} state_t;

    state_t                 state, state_nxt;
    logic [req_width-1:0]   ptr;
    logic [req_width-1:0]   g_idx;
    logic [req_width-1:0]   arb_idx;
    logic                   arb_hit;
    logic [trans_width-1:0] beat_cnt;
    logic                   beat;
    logic                   last_beat;

    // Rotating search starting just after the last owner.
    always_comb begin
        logic [req_width-1:0] cand;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int i = 1; i <= num_req; i++) begin
            cand = req_width'((int'(ptr) + i) % num_req);
            if (!arb_hit && s_valid[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
    end

    assign beat      = (state == XFER) && s_valid[g_idx] && m_ready;
    assign last_beat = beat && (beat_cnt == trans_width'(trans_lenth - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        m_data    = '0;
        m_valid   = 1'b0;
        s_ready   = '0;
        case (state)
            IDLE: if (arb_hit) state_nxt = EN;
            EN:   state_nxt = XFER;
            XFER: begin
                for (int i = 0; i < num_req; i++) begin
                    if (g_idx == req_width'(i)) m_data = s_data[i*data_width +: data_width];
                end
                m_valid        = s_valid[g_idx];
                s_ready[g_idx] = m_ready;
                if (last_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign en   = (state == EN);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant      <= '0;
            g_idx      <= '0;
            ptr        <= req_width'(num_req - 1);
            beat_cnt   <= '0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            if (state == IDLE && arb_hit) begin
                grant <= num_req'(1) << arb_idx;
                g_idx <= arb_idx;
            end
            if (beat) begin
                if (last_beat) begin
                    beat_cnt   <= '0;
                    ptr        <= g_idx;
                    grant      <= '0;
                    burst_done <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

endmodule
